nokia_lcd_sequencer: RTL and testbench

//  Sequences spi_master for the Nokia 5110 (PCD8544) display. After reset it pulses the LCD reset pin
//  and sends the init command list. It then streams a 504-byte framebuffer (84x48, 6 banks) from a

---
 rtl/nokia_lcd_sequencer_pkg.sv | 48 ++++
 rtl/nokia_lcd_sequencer_if.sv | 14 +
 rtl/nokia_lcd_sequencer_byte_tx.sv | 69 ++++++
 rtl/nokia_lcd_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_nokia_lcd_sequencer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/nokia_lcd_sequencer_pkg.sv
// rtl/nokia_lcd_sequencer_pkg.sv - shared types and PCD8544 command constants for the LCD sequencer
// Contents: main/byte-handshake FSM state enums, command byte constants,
//           init-list length and the init-list lookup function.
package nokia_lcd_pkg;

    typedef enum logic [3:0] {
        ST_RST_LOW,
        ST_RST_WAIT,
        ST_INIT,
        ST_IDLE,
        ST_INV,
        ST_ADDR,
        ST_FB_RD,
        ST_FB_TX,
        ST_DONE
    } main_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_REQ,
        TX_WAIT
    } tx_state_e;

    localparam logic [7:0] FUNC_EXT  = 8'h21;
    localparam logic [7:0] TEMP      = 8'h04;
    localparam logic [7:0] BIAS      = 8'h14;
    localparam logic [7:0] FUNC_BAS  = 8'h20;
    localparam logic [7:0] DISP_NORM = 8'h0C;
    localparam logic [7:0] DISP_INV  = 8'h0D;
    localparam logic [7:0] SET_X0    = 8'h80;
    localparam logic [7:0] SET_Y0    = 8'h40;

    localparam int INIT_LEN = 6;

    // Init list: extended mode, contrast, temp coeff, bias, basic mode, display control.
    function automatic logic [7:0] init_byte(input logic [2:0] idx, input logic [7:0] vop,
                                             input logic inv);
        case (idx)
            3'd0:    init_byte = FUNC_EXT;
            3'd1:    init_byte = vop;
            3'd2:    init_byte = TEMP;
            3'd3:    init_byte = BIAS;
            3'd4:    init_byte = FUNC_BAS;
            default: init_byte = inv ? DISP_INV : DISP_NORM;
        endcase
    endfunction

endpackage

// File: rtl/nokia_lcd_sequencer_if.sv
// rtl/nokia_lcd_sequencer_if.sv - sequencer-to-spi_master byte interface
// Signals: start (byte request), data (byte), cmd (0=command, 1=RAM data),
//          div (spi_master clock divider), busy (spi_master busy).
// Modports: master = sequencer side, slave = spi_master side.
interface nokia_lcd_sequencer_if;
    logic        start;
    logic [7:0]  data;
    logic        cmd;
    logic [15:0] div;
    logic        busy;

    modport master (output start, output data, output cmd, output div, input busy);
    modport slave  (input start, input data, input cmd, input div, output busy);
endinterface

// File: rtl/nokia_lcd_sequencer_byte_tx.sv
// rtl/nokia_lcd_sequencer_byte_tx.sv - one-byte start/busy handshake towards spi_master
// Ports: clk, reset (async, active-high); go_i/byte_i/cmd_i request a byte (accepted when idle);
//        spi_busy_i from spi_master; spi_start_o/spi_data_o/spi_cmd_o to spi_master;
//        done_o pulses for one cycle when spi_master has finished the byte.
module lcd_byte_tx
    import nokia_lcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       go_i,
    input  logic [7:0] byte_i,
    input  logic       cmd_i,
    input  logic       spi_busy_i,
    output logic       spi_start_o,
    output logic [7:0] spi_data_o,
    output logic       spi_cmd_o,
    output logic       done_o
);

    tx_state_e  state_q, state_d;
    logic [7:0] data_q, data_d;
    logic       cmd_q, cmd_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= TX_IDLE;
            data_q  <= 8'h00;
            cmd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cmd_q   <= cmd_d;
        end
    end

    // start stays high up to and including the first cycle busy is seen (acceptance),
    // so spi_master can never miss it and never sees it again afterwards.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        cmd_d       = cmd_q;
        spi_start_o = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (go_i) begin
                    data_d  = byte_i;
                    cmd_d   = cmd_i;
                    state_d = TX_REQ;
                end
            end
            TX_REQ: begin
                spi_start_o = 1'b1;
                if (spi_busy_i) state_d = TX_WAIT;
            end
            TX_WAIT: begin
                if (!spi_busy_i) begin
                    done_o  = 1'b1;
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    assign spi_data_o = data_q;
    assign spi_cmd_o  = cmd_q;

endmodule

// File: rtl/nokia_lcd_sequencer.sv
// rtl/nokia_lcd_sequencer.sv - PCD8544 (Nokia 5110) reset/init/framebuffer sequencer for spi_master
// Ports: clk, reset (async, active-high); refresh_req_i (request a frame); fb_data_i (RAM data,
//        1-cycle latency); invert_i (only with LCD_INVERT_EN); fb_addr_o (RAM address);
//        lcd_rst_n_o (LCD reset pin); init_done_o; frame_busy_o; frame_done_o (1-cycle pulse);
//        spi (nokia_lcd_sequencer_if.master) to spi_master.
// Optional feature macro: LCD_INVERT_EN (adds invert_i and display-inversion control).
module nokia_lcd_sequencer
    import nokia_lcd_pkg::*;
#(
    parameter logic [15:0] RST_LOW_CYC  = 16'd50000,
    parameter logic [15:0] RST_WAIT_CYC = 16'd50000,
    parameter logic [15:0] SPI_DIV      = 16'd8,
    parameter logic [7:0]  VOP          = 8'hB1,
    parameter logic [9:0]  FB_BYTES     = 10'd504
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         refresh_req_i,
    input  logic [7:0]                   fb_data_i,
`ifdef LCD_INVERT_EN
    input  logic                         invert_i,
`endif
    output logic [8:0]                   fb_addr_o,
    output logic                         lcd_rst_n_o,
    output logic                         init_done_o,
    output logic                         frame_busy_o,
    output logic                         frame_done_o,
    nokia_lcd_sequencer_if.master        spi
);

    main_state_e state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic        wait_q, wait_d;
    logic [8:0]  addr_q, addr_d;
    logic        pending_q, pending_d;
    logic        init_done_q, init_done_d;
    logic        busy_q, busy_d;
    logic        rstn_q, rstn_d;
    logic        inv_q;

    logic        sending;
    logic        tx_go;
    logic [7:0]  tx_byte;
    logic        tx_cmd;
    logic        tx_done;

`ifdef LCD_INVERT_EN
    logic        inv_d;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) inv_q <= 1'b0;
        else       inv_q <= inv_d;
    end
`else
    assign inv_q = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RST_LOW;
            cnt_q       <= 16'd0;
            idx_q       <= 3'd0;
            wait_q      <= 1'b0;
            addr_q      <= 9'd0;
            pending_q   <= 1'b0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b0;
            rstn_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wait_q      <= wait_d;
            addr_q      <= addr_d;
            pending_q   <= pending_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
            rstn_q      <= rstn_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        addr_d      = addr_q;
        pending_d   = pending_q | refresh_req_i;
        init_done_d = init_done_q;
        busy_d      = busy_q;
        rstn_d      = rstn_q;
`ifdef LCD_INVERT_EN
        inv_d       = inv_q;
`endif
        sending     = 1'b0;
        tx_byte     = 8'h00;
        tx_cmd      = 1'b0;
        case (state_q)
            ST_RST_LOW: begin
                if (cnt_q == RST_LOW_CYC - 16'd1) begin
                    cnt_d   = 16'd0;
                    rstn_d  = 1'b1;
                    state_d = ST_RST_WAIT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RST_WAIT: begin
                if (cnt_q == RST_WAIT_CYC - 16'd1) begin
                    cnt_d   = 16'd0;
                    idx_d   = 3'd0;
                    state_d = ST_INIT;
`ifdef LCD_INVERT_EN
                    inv_d   = invert_i;
`endif
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_INIT: begin
                sending = 1'b1;
                tx_byte = init_byte(idx_q, VOP, inv_q);
                if (tx_done) begin
                    if (idx_q == 3'(INIT_LEN - 1)) begin
                        init_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_IDLE: begin
`ifdef LCD_INVERT_EN
                // An inversion change is applied before any pending frame.
                if (invert_i != inv_q) begin
                    inv_d   = invert_i;
                    state_d = ST_INV;
                end else
`endif
                if (pending_q) begin
                    // A request arriving in this very cycle still counts for the next frame.
                    pending_d = refresh_req_i;
                    busy_d    = 1'b1;
                    idx_d     = 3'd0;
                    state_d   = ST_ADDR;
                end
            end
            ST_INV: begin
                sending = 1'b1;
                tx_byte = inv_q ? DISP_INV : DISP_NORM;
                if (tx_done) state_d = ST_IDLE;
            end
            ST_ADDR: begin
                sending = 1'b1;
                tx_byte = idx_q[0] ? SET_Y0 : SET_X0;
                if (tx_done) begin
                    if (idx_q[0]) state_d = ST_FB_RD;
                    else          idx_d   = 3'd1;
                end
            end
            ST_FB_RD: begin
                state_d = ST_FB_TX;
            end
            ST_FB_TX: begin
                // fb_data_i is valid here because the address was presented in ST_FB_RD;
                // the byte is captured by lcd_byte_tx when the request is issued.
                sending = 1'b1;
                tx_byte = fb_data_i;
                tx_cmd  = 1'b1;
                if (tx_done) begin
                    if ({1'b0, addr_q} == FB_BYTES - 10'd1) begin
                        addr_d  = 9'd0;
                        busy_d  = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + 9'd1;
                        state_d = ST_FB_RD;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_RST_LOW;
        endcase

        // One request per byte: wait_q is set when a byte is issued and cleared on its completion.
        tx_go = sending & ~wait_q;
        if (tx_go)   wait_d = 1'b1;
        if (tx_done) wait_d = 1'b0;
    end

    lcd_byte_tx u_byte_tx (
        .clk        (clk),
        .reset      (reset),
        .go_i       (tx_go),
        .byte_i     (tx_byte),
        .cmd_i      (tx_cmd),
        .spi_busy_i (spi.busy),
        .spi_start_o(spi.start),
        .spi_data_o (spi.data),
        .spi_cmd_o  (spi.cmd),
        .done_o     (tx_done)
    );

    assign spi.div      = SPI_DIV;
    assign fb_addr_o    = addr_q;
    assign lcd_rst_n_o  = rstn_q;
    assign init_done_o  = init_done_q;
    assign frame_busy_o = busy_q;
    assign frame_done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_nokia_lcd_sequencer.sv
// tb/tb_nokia_lcd_sequencer.sv - scoreboard bench for nokia_lcd_sequencer with SPI and RAM models
module tb_nokia_lcd_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       refresh_req;
    logic [7:0] fb_data;
    logic [8:0] fb_addr;
    logic       lcd_rst_n, init_done, frame_busy, frame_done;
`ifdef LCD_INVERT_EN
    logic       invert;
`endif

    int errors = 0;
    int checks = 0;
    int acc    = 0;
    int fd_cnt = 0;
    int proto_viol = 0;
    logic [8:0] exp_q[$];

    nokia_lcd_sequencer_if spi_if ();

    always #5 clk = ~clk;

    nokia_lcd_sequencer #(
        .RST_LOW_CYC (16'd4),
        .RST_WAIT_CYC(16'd4),
        .SPI_DIV     (16'd2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .refresh_req_i(refresh_req),
        .fb_data_i    (fb_data),
`ifdef LCD_INVERT_EN
        .invert_i     (invert),
`endif
        .fb_addr_o    (fb_addr),
        .lcd_rst_n_o  (lcd_rst_n),
        .init_done_o  (init_done),
        .frame_busy_o (frame_busy),
        .frame_done_o (frame_done),
        .spi          (spi_if)
    );

    // Framebuffer RAM: RAM[i] = i[7:0], one-cycle read latency.
    logic [7:0] ram [512];
    initial for (int i = 0; i < 512; i++) ram[i] = 8'(i);
    always @(posedge clk) fb_data <= ram[fb_addr];

    // spi_master stand-in: accepts start when idle, stays busy for 4 cycles.
    logic       busy_m;
    logic [1:0] bcnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_m <= 1'b0;
            bcnt   <= 2'd0;
        end else if (!busy_m) begin
            if (spi_if.start) begin
                busy_m <= 1'b1;
                bcnt   <= 2'd3;
            end
        end else if (bcnt == 2'd0) begin
            busy_m <= 1'b0;
        end else begin
            bcnt <= bcnt - 2'd1;
        end
    end
    assign spi_if.busy = busy_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_lcd_rst_n"},  32'(lcd_rst_n),     32'd0);
        check({tag, "_spi_start"},  32'(spi_if.start),  32'd0);
        check({tag, "_spi_data"},   32'(spi_if.data),   32'd0);
        check({tag, "_spi_cmd"},    32'(spi_if.cmd),    32'd0);
        check({tag, "_fb_addr"},    32'(fb_addr),       32'd0);
        check({tag, "_init_done"},  32'(init_done),     32'd0);
        check({tag, "_frame_busy"}, 32'(frame_busy),    32'd0);
        check({tag, "_frame_done"}, 32'(frame_done),    32'd0);
    endtask

    task automatic push_init(input logic [7:0] last);
        logic [7:0] lst [6];
        lst = '{8'h21, 8'hB1, 8'h04, 8'h14, 8'h20, last};
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, lst[i]});
    endtask

    task automatic push_frame();
        exp_q.push_back({1'b0, 8'h80});
        exp_q.push_back({1'b0, 8'h40});
        for (int i = 0; i < 504; i++) exp_q.push_back({1'b1, 8'(i)});
    endtask

    task automatic pulse_refresh();
        @(negedge clk);
        refresh_req = 1'b1;
        @(negedge clk);
        refresh_req = 1'b0;
    endtask

    // Wait until every expected byte has gone out and the sequencer is quiet.
    task automatic drain(input string name, input int maxcyc);
        int n = 0;
        while ((exp_q.size() != 0 || frame_busy || spi_if.busy) && n < maxcyc) begin
            @(negedge clk);
            n++;
        end
        repeat (8) @(negedge clk);
        check({name, "_drain_timeout"}, 32'(n >= maxcyc), 32'd0);
        check({name, "_left_in_queue"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_acc(input int target, input int maxcyc);
        int n = 0;
        while (acc < target && n < maxcyc) begin
            @(negedge clk);
            n++;
        end
        check("wait_bytes_timeout", 32'(n >= maxcyc), 32'd0);
    endtask

    task automatic wait_fd(input int target, input int maxcyc);
        int n = 0;
        while (fd_cnt < target && n < maxcyc) begin
            @(negedge clk);
            n++;
        end
        check("wait_frame_done_timeout", 32'(n >= maxcyc), 32'd0);
    endtask

    // Monitor: every byte handed to spi_master is popped from the scoreboard and compared.
    task automatic monitor();
        logic [8:0] got, exp, lat;
        logic       prev_sb;
        prev_sb = 1'b0;
        lat     = 9'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_sb = 1'b0;
            end else begin
                if (frame_done) fd_cnt++;
                if (spi_if.start && spi_if.busy && prev_sb) proto_viol++;
                if (spi_if.busy && {spi_if.cmd, spi_if.data} != lat) proto_viol++;
                prev_sb = spi_if.start && spi_if.busy;
                if (spi_if.start && !spi_if.busy) begin
                    got = {spi_if.cmd, spi_if.data};
                    lat = got;
                    acc++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL spi_byte #%0d: got dc=%0d %02h, nothing expected",
                                 acc, got[8], got[7:0]);
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            errors++;
                            $display("FAIL spi_byte #%0d: got dc=%0d %02h, expected dc=%0d %02h",
                                     acc, got[8], got[7:0], exp[8], exp[7:0]);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        int n;
        int base;
        reset       = 1'b1;
        refresh_req = 1'b0;
`ifdef LCD_INVERT_EN
        invert      = 1'b0;
`endif
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check_reset("por");
        check("spi_div", 32'(spi_if.div), 32'd2);

        // Power-up: reset pulse length and init list.
        push_init(8'h0C);
        reset = 1'b0;
        n = 0;
        while (lcd_rst_n == 1'b0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("rst_low_cycles", 32'(n), 32'd4);
        drain("init", 500);
        check("init_done", 32'(init_done), 32'd1);

        // Single frame.
        push_frame();
        pulse_refresh();
        drain("frame1", 6000);
        check("frame1_done_count", 32'(fd_cnt), 32'd1);
        check("frame1_fb_addr", 32'(fb_addr), 32'd0);
        check("frame1_busy", 32'(frame_busy), 32'd0);

        // Three requests during a frame coalesce into one more frame.
        push_frame();
        push_frame();
        pulse_refresh();
        wait_acc(acc + 50, 2000);
        repeat (3) begin
            pulse_refresh();
            repeat (20) @(negedge clk);
        end
        drain("coalesce", 12000);
        repeat (100) @(negedge clk);
        check("coalesce_done_count", 32'(fd_cnt), 32'd3);

        // Reset at data byte 100: everything aborts, full init is redone, no frame follows.
        push_frame();
        base = acc;
        pulse_refresh();
        wait_acc(base + 102, 2000);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_reset("midframe");
        repeat (2) @(negedge clk);
        push_init(8'h0C);
        reset = 1'b0;
        drain("reinit", 500);
        check("reinit_done", 32'(init_done), 32'd1);
        repeat (100) @(negedge clk);
        check("reinit_done_count", 32'(fd_cnt), 32'd3);

        // refresh_req held high: back-to-back frames until it drops.
        push_frame();
        push_frame();
        push_frame();
        refresh_req = 1'b1;
        wait_fd(4, 6000);
        wait_acc(acc + 50, 2000);
        refresh_req = 1'b0;
        drain("held", 15000);
        repeat (100) @(negedge clk);
        check("held_done_count", 32'(fd_cnt), 32'd6);

`ifdef LCD_INVERT_EN
        // Inversion change in IDLE sends a single display-control command only.
        exp_q.push_back({1'b0, 8'h0D});
        @(negedge clk);
        invert = 1'b1;
        drain("invert", 500);
        repeat (100) @(negedge clk);
        check("invert_done_count", 32'(fd_cnt), 32'd6);
`endif

        check("handshake_violations", 32'(proto_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
